// File: rtl/lsu_pipe.sv
// Load/store unit: one outstanding word-RAM transaction per accepted request,
// with lane alignment, sign/zero extension, misalign and timeout errors.
package imhotep_pkg;
  parameter int unsigned XLEN      = 32;
  parameter int unsigned RAM_WIDTH = 16;

  typedef enum logic [3:0] {
    LSU_NOP = 4'd0,
    LSU_LW  = 4'd1,
    LSU_LH  = 4'd2,
    LSU_LHU = 4'd3,
    LSU_LB  = 4'd4,
    LSU_LBU = 4'd5,
    LSU_SW  = 4'd6,
    LSU_SH  = 4'd7,
    LSU_SB  = 4'd8
  } op_lsu_e;
endpackage

module lsu_pipe
  import imhotep_pkg::*;
#(
  parameter int unsigned ADDR_W  = RAM_WIDTH,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  op_lsu_e             op_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  output logic                rsp_valid_o,
  output logic [XLEN-1:0]     rdata_o,
  output logic                err_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic                mem_we_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  input  logic                mem_rvalid_i,
  input  logic [XLEN-1:0]     mem_rdata_i,
  output logic                busy_o
);

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  op_lsu_e             op_q, op_d;
  logic [1:0]          off_q, off_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [NBYTES-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                is_ld, is_st, is_word, is_half, misaligned;
  logic [NBYTES-1:0]   lane_mask;
  logic [XLEN-1:0]     ld_shift, ld_ext;

  // Decode the incoming op into class, width, alignment and lane mask
  always_comb begin
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_word = 1'b0;
    is_half = 1'b0;
    case (op_i)
      LSU_LW:          begin is_ld = 1'b1; is_word = 1'b1; end
      LSU_LH, LSU_LHU: begin is_ld = 1'b1; is_half = 1'b1; end
      LSU_LB, LSU_LBU: begin is_ld = 1'b1; end
      LSU_SW:          begin is_st = 1'b1; is_word = 1'b1; end
      LSU_SH:          begin is_st = 1'b1; is_half = 1'b1; end
      LSU_SB:          begin is_st = 1'b1; end
      default:         ;
    endcase
    misaligned = (is_word && (addr_i[1:0] != 2'b00)) || (is_half && addr_i[0]);
    if (is_word)      lane_mask = '1;
    else if (is_half) lane_mask = NBYTES'(2'b11) << addr_i[1:0];
    else              lane_mask = NBYTES'(1'b1) << addr_i[1:0];
  end

  // Align the returned word to lane 0 and extend by load type
  always_comb begin
    ld_shift = mem_rdata_i >> {off_q, 3'b000};
    case (op_q)
      LSU_LB:  ld_ext = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      LSU_LBU: ld_ext = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      LSU_LH:  ld_ext = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      LSU_LHU: ld_ext = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      LSU_LW:  ld_ext = ld_shift;
      default: ld_ext = '0;
    endcase
  end

  // Next-state and registered-output logic for the transaction FSM
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d  = op_i;
          off_d = addr_i[1:0];
          cnt_d = '0;
          if (op_i == LSU_NOP) begin
            state_d = S_RESP;
            err_d   = 1'b0;
            rdata_d = '0;
          end else if (!(is_ld || is_st) || misaligned) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = S_ISSUE;
            mem_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
            mem_we_d    = is_st;
            mem_be_d    = lane_mask;
            mem_wdata_d = is_st ? (wdata_i << {addr_i[1:0], 3'b000}) : '0;
          end
        end
      end
      S_ISSUE: begin
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
        if (mem_gnt_i) begin
          state_d = S_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_WAIT: begin
        // Counter saturates so a grant on the last cycle still times out
        // one cycle later if no response follows.
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid_i) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = ld_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_req_d   = (state_d == S_ISSUE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= LSU_NOP;
      off_q       <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o = rst_ni && (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed self-checking bench for lsu_pipe with a scripted memory responder.
module tb_lsu_pipe;
  import imhotep_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  op_lsu_e     op_i = LSU_NOP;
  logic [15:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Results captured by txn
  int          lat;
  logic [31:0] r;
  logic        e, seen, we, stable;
  logic [15:0] maddr;
  logic [3:0]  be;
  logic [31:0] wdo;

  lsu_pipe #(.ADDR_W(16), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Issue one request and play memory: grant after gdly request cycles
  // (-1 = never), respond rdly cycles after the grant (-1 = never).
  // lat is the cycle (after the accept edge) at which rsp_valid_o is seen.
  task automatic txn(input op_lsu_e op, input logic [15:0] addr, input logic [31:0] wd,
                     input int gdly, input int rdly, input logic [31:0] rd);
    int gw, rw;
    bit granted, done;
    lat = -1; r = '0; e = 1'b0; seen = 1'b0; maddr = '0; be = '0; wdo = '0;
    we = 1'b0; stable = 1'b1; gw = 0; rw = 0; granted = 1'b0; done = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd;
    @(posedge clk_i);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      if (rsp_valid_o) begin
        lat = cyc; r = rdata_o; e = err_o;
        break;
      end
      if (mem_req_o) begin
        if (!seen) begin
          seen = 1'b1; maddr = mem_addr_o; be = mem_be_o; wdo = mem_wdata_o; we = mem_we_o;
        end else if (mem_addr_o !== maddr || mem_be_o !== be || mem_wdata_o !== wdo || mem_we_o !== we) begin
          stable = 1'b0;
        end
        if (gdly >= 0 && gw == gdly) begin
          mem_gnt_i = 1'b1; granted = 1'b1;
        end else gw++;
      end else if (granted && !done) begin
        if (rdly >= 0 && rw == rdly) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = rd; done = 1'b1;
        end else rw++;
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, rsp_valid_o, rdata_o, err_o, busy_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b be=%h addr=%h wd=%h rsp=%b rd=%h err=%b busy=%b, required all 0",
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, rsp_valid_o, rdata_o, err_o, busy_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", req_ready_o); end
  endtask

  task automatic test_word();
    txn(LSU_SW, 16'h0010, 32'hDEADBEEF, 0, 0, 32'h0);
    n_tests++; if (be !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b required 1111", be); end
    n_tests++; if (wdo !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h required deadbeef", wdo); end
    n_tests++; if (maddr !== 16'h0010 || we !== 1'b1) begin n_fail++; $display("FAIL sw_addr_we: got %h/%b required 0010/1", maddr, we); end
    n_tests++; if (lat !== 3 || e !== 1'b0 || r !== 32'h0) begin n_fail++; $display("FAIL sw_rsp: lat %0d err %b rd %h, required 3 0 0", lat, e, r); end
    txn(LSU_LW, 16'h0010, 32'h0, 0, 0, 32'hDEADBEEF);
    n_tests++; if (r !== 32'hDEADBEEF || e !== 1'b0) begin n_fail++; $display("FAIL lw_rdata: got %h err %b required deadbeef 0", r, e); end
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d required 3", lat); end
    n_tests++; if (we !== 1'b0 || be !== 4'b1111 || wdo !== 32'h0) begin n_fail++; $display("FAIL lw_fields: we %b be %b wd %h required 0 1111 0", we, be, wdo); end
  endtask

  task automatic test_sub_store();
    txn(LSU_SB, 16'h0013, 32'h000000A5, 0, 0, 32'h0);
    n_tests++; if (maddr !== 16'h0010 || be !== 4'b1000 || wdo !== 32'hA5000000) begin
      n_fail++; $display("FAIL sb_fields: addr %h be %b wd %h required 0010 1000 a5000000", maddr, be, wdo); end
    txn(LSU_SH, 16'h0012, 32'h00001234, 0, 0, 32'h0);
    n_tests++; if (maddr !== 16'h0010 || be !== 4'b1100 || wdo !== 32'h12340000 || e !== 1'b0) begin
      n_fail++; $display("FAIL sh_fields: addr %h be %b wd %h err %b required 0010 1100 12340000 0", maddr, be, wdo, e); end
  endtask

  task automatic test_sub_load();
    op_lsu_e     ops [8] = '{LSU_LB, LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LB, LSU_LH, LSU_LW};
    logic [15:0] ads [8] = '{16'h21, 16'h23, 16'h23, 16'h22, 16'h22, 16'h20, 16'h20, 16'h20};
    logic [31:0] exr [8] = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80F0,
                             32'h000080F0, 32'h00000001, 32'h00007F01, 32'h80F07F01};
    logic [3:0]  exb [8] = '{4'b0010, 4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0001, 4'b0011, 4'b1111};
    for (int i = 0; i < 8; i++) begin
      txn(ops[i], ads[i], 32'hFFFFFFFF, 0, 0, 32'h80F07F01);
      n_tests++;
      if (r !== exr[i] || be !== exb[i] || maddr !== 16'h0020 || e !== 1'b0 || wdo !== 32'h0) begin
        n_fail++;
        $display("FAIL load_%0d: rd %h be %b addr %h err %b wd %h, required %h %b 0020 0 0",
                 i, r, be, maddr, e, wdo, exr[i], exb[i]);
      end
    end
  endtask

  task automatic test_local();
    op_lsu_e     ops [5] = '{LSU_LW, LSU_SH, LSU_LH, LSU_NOP, op_lsu_e'(4'd12)};
    logic [15:0] ads [5] = '{16'h11, 16'h13, 16'h11, 16'h44, 16'h40};
    logic        exe [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      txn(ops[i], ads[i], 32'h5555AAAA, 0, 0, 32'h0);
      n_tests++;
      if (lat !== 1 || seen !== 1'b0 || e !== exe[i] || r !== 32'h0) begin
        n_fail++;
        $display("FAIL local_%0d: lat %0d memreq %b err %b rd %h, required 1 0 %b 0", i, lat, seen, e, r, exe[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i); req_valid_i = 1'b1; op_i = LSU_NOP; addr_i = '0;
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_c1: rsp %b ready %b required 1 0", rsp_valid_o, req_ready_o); end
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_c2: rsp %b ready %b required 0 1", rsp_valid_o, req_ready_o); end
    @(negedge clk_i); req_valid_i = 1'b0;
    n_tests++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_c3: rsp %b required 1", rsp_valid_o); end
  endtask

  task automatic test_stall();
    txn(LSU_SW, 16'h0044, 32'hCAFEF00D, 3, 0, 32'h0);
    n_tests++; if (stable !== 1'b1 || maddr !== 16'h0044 || wdo !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL stall_stable: stable %b addr %h wd %h required 1 0044 cafef00d", stable, maddr, wdo); end
    n_tests++; if (lat !== 6 || e !== 1'b0) begin n_fail++; $display("FAIL stall_lat: got %0d err %b required 6 0", lat, e); end
    txn(LSU_LHU, 16'h0046, 32'h0, 1, 2, 32'hBEEF1234);
    n_tests++; if (lat !== 6 || r !== 32'h0000BEEF) begin n_fail++; $display("FAIL rv_delay: lat %0d rd %h required 6 0000beef", lat, r); end
    // Grant on the last counted cycle beats the timeout
    txn(LSU_LW, 16'h0048, 32'h0, 15, 0, 32'h01020304);
    n_tests++; if (lat !== 18 || e !== 1'b0 || r !== 32'h01020304) begin
      n_fail++; $display("FAIL gnt_at_limit: lat %0d err %b rd %h required 18 0 01020304", lat, e, r); end
  endtask

  task automatic test_timeout();
    txn(LSU_LW, 16'h0050, 32'h0, -1, 0, 32'h0);
    n_tests++; if (lat !== 17 || e !== 1'b1 || r !== 32'h0) begin
      n_fail++; $display("FAIL to_issue: lat %0d err %b rd %h required 17 1 0", lat, e, r); end
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL to_req_clear: got %b required 0", mem_req_o); end
    @(negedge clk_i); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77777777;
    @(negedge clk_i); mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL late_rvalid: rsp %b busy %b required 0 0", rsp_valid_o, busy_o); end
    txn(LSU_LW, 16'h0054, 32'h0, 0, 0, 32'h13579BDF);
    n_tests++; if (lat !== 3 || e !== 1'b0 || r !== 32'h13579BDF) begin
      n_fail++; $display("FAIL after_to: lat %0d err %b rd %h required 3 0 13579bdf", lat, e, r); end
    txn(LSU_LB, 16'h0058, 32'h0, 0, -1, 32'h0);
    n_tests++; if (lat !== 17 || e !== 1'b1) begin n_fail++; $display("FAIL to_wait: lat %0d err %b required 17 1", lat, e); end
  endtask

  task automatic test_reset_mid();
    bit saw_rsp;
    saw_rsp = 1'b0;
    @(negedge clk_i); req_valid_i = 1'b1; op_i = LSU_LW; addr_i = 16'h0060;
    @(negedge clk_i); req_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk_i); mem_gnt_i = 1'b0;
    n_tests++; if (busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_wait: busy %b req %b required 1 0", busy_o, mem_req_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, rsp_valid_o, rdata_o, err_o, busy_o} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: req=%b we=%b be=%h addr=%h wd=%h rsp=%b rd=%h err=%b busy=%b, required all 0",
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, rsp_valid_o, rdata_o, err_o, busy_o);
    end
    @(negedge clk_i); @(negedge clk_i); rst_ni = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h66666666;
    @(negedge clk_i); mem_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid_o) saw_rsp = 1'b1;
      @(negedge clk_i);
    end
    n_tests++; if (saw_rsp !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp: got %b required 0", saw_rsp); end
    txn(LSU_LW, 16'h0064, 32'h0, 0, 0, 32'h2468ACE0);
    n_tests++; if (lat !== 3 || e !== 1'b0 || r !== 32'h2468ACE0) begin
      n_fail++; $display("FAIL post_reset_lw: lat %0d err %b rd %h required 3 0 2468ace0", lat, e, r); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    test_reset();
    test_word();
    test_sub_store();
    test_sub_load();
    test_local();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
